// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a single BRAM master port.
// Each grant runs IDLE/RESP -> ISSUE -> WAIT -> RESP, giving one access
// every three cycles. Illegal addresses still walk the full sequence,
// but the BRAM is never enabled and the access completes with err set.
module bram_port_arbiter #(
   parameter logic [31:0] ADDR_HIGH = 32'd4092,
   parameter bit          RR_EN     = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wrdata0,
   input  logic [31:0] wrdata1,
   input  logic [3:0]  we0,
   input  logic [3:0]  we1,
   output logic        ack0,
   output logic        ack1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata,
   output logic        busy,
   output logic [31:0] bram_addr,
   output logic        bram_clk,
   output logic [31:0] bram_wrdata,
   input  logic [31:0] bram_rddata,
   output logic        bram_en,
   output logic        bram_rst,
   output logic [3:0]  bram_we
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state;
   logic        gnt_idx;
   logic        gnt_err;
   logic        rr_ptr;

   logic        any_req;
   logic        prio;
   logic        win;
   logic        win_bad;
   logic [31:0] win_addr;
   logic [31:0] win_wrdata;
   logic [3:0]  win_we;

   assign bram_clk = clk;
   assign bram_rst = ~rst_n;

   // Winner selection and address legality check for the next grant.
   // From RESP the requester just served yields priority directly, because
   // the pointer update and the back-to-back grant share the same edge.
   always_comb begin
      prio = 1'b0;
      if (RR_EN) begin
         prio = (state == RESP) ? ~gnt_idx : rr_ptr;
      end
      any_req    = req0 | req1;
      win        = (req0 & req1) ? prio : req1;
      win_addr   = win ? addr1   : addr0;
      win_wrdata = win ? wrdata1 : wrdata0;
      win_we     = win ? we1     : we0;
      win_bad    = (win_addr > ADDR_HIGH) || (win_addr[1:0] != 2'b00);
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gnt_idx     <= 1'b0;
         gnt_err     <= 1'b0;
         rr_ptr      <= 1'b0;
         busy        <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err0        <= 1'b0;
         err1        <= 1'b0;
         rdata       <= '0;
         bram_en     <= 1'b0;
         bram_we     <= '0;
         bram_addr   <= '0;
         bram_wrdata <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         case (state)
            ISSUE: begin
               bram_en <= 1'b0;
               bram_we <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               rdata <= gnt_err ? '0 : bram_rddata;
               ack0  <= ~gnt_idx;
               ack1  <= gnt_idx;
               err0  <= ~gnt_idx & gnt_err;
               err1  <= gnt_idx & gnt_err;
               state <= RESP;
            end
            default: begin
               // IDLE and RESP both accept a new grant
               if (state == RESP && RR_EN) begin
                  rr_ptr <= ~gnt_idx;
               end
               if (any_req) begin
                  gnt_idx     <= win;
                  gnt_err     <= win_bad;
                  bram_addr   <= win_addr;
                  bram_wrdata <= win_wrdata;
                  bram_we     <= win_bad ? '0 : win_we;
                  bram_en     <= ~win_bad;
                  busy        <= 1'b1;
                  state       <= ISSUE;
               end else begin
                  bram_en <= 1'b0;
                  bram_we <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: one round-robin and one fixed-priority
// instance share the requester inputs, each with its own BRAM model.
// A transaction-level reference model predicts every output each cycle;
// directed sequences add literal expectations.
module tb_bram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wrdata0 = '0, wrdata1 = '0;
   logic [3:0]  we0 = '0, we1 = '0;

   // lane 0: RR_EN=1, lane 1: RR_EN=0
   logic [1:0]  ack0, ack1, err0, err1, busy, bram_en, bram_clk, bram_rst;
   logic [31:0] rdata [2];
   logic [31:0] bram_addr [2];
   logic [31:0] bram_wrdata [2];
   logic [31:0] bram_rddata [2];
   logic [3:0]  bram_we [2];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(.ADDR_HIGH(32'd4092), .RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wrdata0(wrdata0), .wrdata1(wrdata1), .we0(we0), .we1(we1),
      .ack0(ack0[0]), .ack1(ack1[0]), .err0(err0[0]), .err1(err1[0]),
      .rdata(rdata[0]), .busy(busy[0]),
      .bram_addr(bram_addr[0]), .bram_clk(bram_clk[0]),
      .bram_wrdata(bram_wrdata[0]), .bram_rddata(bram_rddata[0]),
      .bram_en(bram_en[0]), .bram_rst(bram_rst[0]), .bram_we(bram_we[0])
   );

   bram_port_arbiter #(.ADDR_HIGH(32'd4092), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wrdata0(wrdata0), .wrdata1(wrdata1), .we0(we0), .we1(we1),
      .ack0(ack0[1]), .ack1(ack1[1]), .err0(err0[1]), .err1(err1[1]),
      .rdata(rdata[1]), .busy(busy[1]),
      .bram_addr(bram_addr[1]), .bram_clk(bram_clk[1]),
      .bram_wrdata(bram_wrdata[1]), .bram_rddata(bram_rddata[1]),
      .bram_en(bram_en[1]), .bram_rst(bram_rst[1]), .bram_we(bram_we[1])
   );

   task automatic chk(input string nm, input int lane,
                      input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s lane%0d: got %h expected %h at %0t", nm, lane, act, exp, $time);
      end
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // BRAM models: synchronous, write-first, byte enables
   logic [31:0] mem [2][1024];
   bit          mem_init = 1'b0;
   always @(posedge clk) begin : bram_model
      logic [9:0] bi;
      if (!mem_init) begin
         for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 1024; i++) mem[l][i] = '0;
            mem[l][4] = 32'hDEADBEEF;
         end
         mem_init = 1'b1;
      end
      for (int l = 0; l < 2; l++) begin
         if (bram_en[l]) begin
            bi = bram_addr[l][11:2];
            for (int b = 0; b < 4; b++)
               if (bram_we[l][b]) mem[l][bi][8*b +: 8] = bram_wrdata[l][8*b +: 8];
            bram_rddata[l] <= mem[l][bi];
         end
      end
   end

   // Reference model: tracks cycles elapsed since the current grant per lane
   logic [31:0] shadow [2][1024];
   bit          sh_init = 1'b0;
   int          age [2] = '{-1, -1};
   bit          gi [2] = '{0, 0};
   bit          gbad [2] = '{0, 0};
   bit          prio [2] = '{0, 0};
   logic [31:0] gaddr [2] = '{0, 0};
   logic [31:0] gwd [2] = '{0, 0};
   logic [3:0]  gwe [2] = '{0, 0};
   logic [1:0]  e_en = '0, e_ack0 = '0, e_ack1 = '0, e_err0 = '0, e_err1 = '0, e_busy = '0;
   logic [3:0]  e_we [2] = '{0, 0};
   logic [31:0] e_addr [2] = '{0, 0};
   logic [31:0] e_wd [2] = '{0, 0};
   logic [31:0] e_rdata [2] = '{0, 0};

   always @(posedge clk or negedge rst_n) begin : ref_model
      logic [9:0]  si;
      logic [31:0] a;
      bit          w;
      if (!sh_init) begin
         for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 1024; i++) shadow[l][i] = '0;
            shadow[l][4] = 32'hDEADBEEF;
         end
         sh_init = 1'b1;
      end
      if (!rst_n) begin
         for (int l = 0; l < 2; l++) begin
            age[l] = -1; prio[l] = 1'b0;
            e_we[l] = '0; e_addr[l] = '0; e_wd[l] = '0; e_rdata[l] = '0;
         end
         e_en = '0; e_ack0 = '0; e_ack1 = '0; e_err0 = '0; e_err1 = '0; e_busy = '0;
      end else begin
         for (int l = 0; l < 2; l++) begin
            e_ack0[l] = 1'b0; e_ack1[l] = 1'b0; e_err0[l] = 1'b0; e_err1[l] = 1'b0;
            if (age[l] == 0) begin
               age[l] = 1; e_en[l] = 1'b0; e_we[l] = '0;
            end else if (age[l] == 1) begin
               age[l] = 2;
               if (gbad[l]) e_rdata[l] = '0;
               else begin
                  si = gaddr[l][11:2];
                  for (int b = 0; b < 4; b++)
                     if (gwe[l][b]) shadow[l][si][8*b +: 8] = gwd[l][8*b +: 8];
                  e_rdata[l] = shadow[l][si];
               end
               if (gi[l]) begin e_ack1[l] = 1'b1; e_err1[l] = gbad[l]; end
               else       begin e_ack0[l] = 1'b1; e_err0[l] = gbad[l]; end
            end else begin
               if (age[l] == 2 && l == 0) prio[l] = !gi[l];
               if (req0 || req1) begin
                  w = (req0 && req1) ? prio[l] : req1;
                  a = w ? addr1 : addr0;
                  gi[l] = w; gaddr[l] = a;
                  gwd[l] = w ? wrdata1 : wrdata0;
                  gwe[l] = w ? we1 : we0;
                  gbad[l] = (a > 32'd4092) || (a[1:0] != 2'b00);
                  age[l] = 0;
                  e_en[l] = !gbad[l];
                  e_we[l] = gbad[l] ? 4'h0 : gwe[l];
                  e_addr[l] = a; e_wd[l] = gwd[l];
                  e_busy[l] = 1'b1;
               end else begin
                  age[l] = -1; e_busy[l] = 1'b0;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         chk("bram_en", l, bram_en[l], e_en[l]);
         chk("bram_we", l, bram_we[l], e_we[l]);
         chk("bram_addr", l, bram_addr[l], e_addr[l]);
         chk("bram_wrdata", l, bram_wrdata[l], e_wd[l]);
         chk("ack0", l, ack0[l], e_ack0[l]);
         chk("ack1", l, ack1[l], e_ack1[l]);
         chk("err0", l, err0[l], e_err0[l]);
         chk("err1", l, err1[l], e_err1[l]);
         chk("rdata", l, rdata[l], e_rdata[l]);
         chk("busy", l, busy[l], e_busy[l]);
         chk("bram_clk", l, bram_clk[l], clk);
         chk("bram_rst", l, bram_rst[l], !rst_n);
      end
   end

   // One isolated transaction with literal expectations on both lanes
   task automatic do_single(input bit p, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] we, input bit x_err, input logic [31:0] x_rd);
      @(negedge clk);
      if (p) begin req1 = 1'b1; addr1 = a; wrdata1 = wd; we1 = we; end
      else   begin req0 = 1'b1; addr0 = a; wrdata0 = wd; we0 = we; end
      @(posedge clk); #1;
      for (int l = 0; l < 2; l++) begin
         chk("issue_en", l, bram_en[l], !x_err);
         if (!x_err) chk("issue_addr", l, bram_addr[l], a);
      end
      @(posedge clk); #1;
      for (int l = 0; l < 2; l++) chk("wait_en", l, bram_en[l], 0);
      @(posedge clk); #1;
      for (int l = 0; l < 2; l++) begin
         chk("resp_ack", l, p ? ack1[l] : ack0[l], 1);
         chk("resp_other_ack", l, p ? ack0[l] : ack1[l], 0);
         chk("resp_err", l, p ? err1[l] : err0[l], x_err);
         chk("resp_rdata", l, rdata[l], x_rd);
      end
      @(negedge clk);
      if (p) req1 = 1'b0; else req0 = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      int rr_seq[$];
      int fp_seq[$];
      int fp0, fp1, dly;

      repeat (3) @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk("rst_busy", l, busy[l], 0);
         chk("rst_ack", l, {ack0[l], ack1[l]}, 0);
         chk("rst_en", l, bram_en[l], 0);
         chk("rst_bram_rst", l, bram_rst[l], 1);
      end
      rst_n = 1'b1;

      do_single(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
      do_single(1'b1, 32'hFFC, 32'h12345678, 4'hF, 1'b0, 32'h12345678);
      do_single(1'b1, 32'hFFC, 32'h0, 4'h0, 1'b0, 32'h12345678);
      do_single(1'b0, 32'h10, 32'hAABBCCDD, 4'b0101, 1'b0, 32'hDEBBBEDD);
      do_single(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEBBBEDD);
      do_single(1'b0, 32'h1000, 32'h55555555, 4'hF, 1'b1, 32'h0);
      do_single(1'b0, 32'h2, 32'h0, 4'h0, 1'b1, 32'h0);
      do_single(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

      // Contention: both held; requester drops on the fixed-priority lane's 4th ack
      @(negedge clk);
      req0 = 1'b1; addr0 = 32'h20; we0 = 4'h0;
      req1 = 1'b1; addr1 = 32'h24; we1 = 4'h0;
      fp0 = 0; fp1 = 0;
      for (int c = 0; c < 200 && (req0 || req1); c++) begin
         @(negedge clk);
         if (ack0[0]) rr_seq.push_back(0);
         if (ack1[0]) rr_seq.push_back(1);
         if (ack0[1]) begin fp_seq.push_back(0); fp0++; if (fp0 == 4) req0 = 1'b0; end
         if (ack1[1]) begin fp_seq.push_back(1); fp1++; if (fp1 == 4) req1 = 1'b0; end
      end
      chk("cont_timeout", 0, {req0, req1}, 0);
      for (int i = 0; i < 4; i++) chk("rr_order", 0, q_at(rr_seq, i), i % 2);
      for (int i = 0; i < 4; i++) chk("fp_order0", 1, q_at(fp_seq, i), 0);
      chk("fp_order1", 1, q_at(fp_seq, 4), 1);
      chk("rr_count", 0, rr_seq.size(), 8);
      repeat (3) @(negedge clk);

      // Reset while in WAIT
      @(negedge clk);
      req0 = 1'b1; addr0 = 32'h10; we0 = 4'h0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0; #1;
      for (int l = 0; l < 2; l++) begin
         chk("mid_rst_en", l, bram_en[l], 0);
         chk("mid_rst_we", l, bram_we[l], 0);
         chk("mid_rst_addr", l, bram_addr[l], 0);
         chk("mid_rst_wd", l, bram_wrdata[l], 0);
         chk("mid_rst_rdata", l, rdata[l], 0);
         chk("mid_rst_acks", l, {ack0[l], ack1[l], err0[l], err1[l]}, 0);
         chk("mid_rst_busy", l, busy[l], 0);
      end
      @(negedge clk); req0 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_noack", 0, {ack0, ack1}, 0);
      end

      // Both request together: requester 0 must win first on both lanes
      req0 = 1'b1; addr0 = 32'h10; we0 = 4'h0;
      req1 = 1'b1; addr1 = 32'h24; we1 = 4'h0;
      dly = 0;
      while (dly < 10 && !(ack0[0] || ack1[0])) begin @(negedge clk); dly++; end
      chk("first_ack_delay", 0, dly, 3);
      for (int l = 0; l < 2; l++) begin
         chk("post_rst_winner", l, {ack1[l], ack0[l]}, 2'b01);
         chk("post_rst_rdata", l, rdata[l], 32'hDEBBBEDD);
      end
      req0 = 1'b0;
      dly = 0;
      do begin @(negedge clk); dly++; end while (dly < 10 && !ack1[0]);
      chk("second_ack_delay", 0, dly, 3);
      chk("second_ack_fp", 1, ack1[1], 1);
      req1 = 1'b0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_HIGH, default 32'd4092, giving the highest legal byte address (4 KB BRAM, word-aligned).
REQ-002 SHALL have parameter RR_EN, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with requester 0 winning.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic; it is also driven out on bram_clk.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports req0/req1, input, 1 bit each: access request; held high until the matching ack.
REQ-006 SHALL have ports addr0/addr1, input, 32 bits each: byte address; held stable while req is high.
REQ-007 SHALL have ports wrdata0/wrdata1, input, 32 bits each: write data.
REQ-008 SHALL have ports we0/we1, input, 4 bits each: byte write enables; 0 means read.
REQ-009 SHALL have ports ack0/ack1, output, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL have ports err0/err1, output, 1 bit each: qualifies ack; 1 means the access was rejected.
REQ-011 SHALL have port rdata, output, 32 bits: read data, valid while ack0 or ack1 is high.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the arbiter is not in IDLE.
REQ-013 SHALL have BRAM master ports: bram_addr (32, out), bram_clk (1, out, equals clk), bram_wrdata (32, out), bram_rddata (32, in), bram_en (1, out), bram_rst (1, out, equals ~rst_n), bram_we (4, out).

Function
REQ-014 SHALL implement four states: IDLE, ISSUE, WAIT and RESP; every output except bram_clk and bram_rst SHALL be registered.
REQ-015 In IDLE with no request pending, SHALL stay in IDLE with bram_en=0 and bram_we=0.
REQ-016 In IDLE with at least one request pending, SHALL select a winner, latch its addr, wrdata and we plus its index, and go to ISSUE.
REQ-017 SHALL arbitrate round-robin when RR_EN=1: on a tie, the requester not granted most recently wins; after reset, requester 0 has priority.
REQ-018 SHALL have ISSUE drive bram_en=1 for exactly one cycle, with the latched bram_addr, bram_wrdata and bram_we.
REQ-019 SHALL enter WAIT with bram_en=0 and bram_we=0, and capture bram_rddata into rdata at the end of WAIT.
REQ-020 In RESP, SHALL assert the granted ack for one cycle and return to IDLE.
REQ-021 SHALL update the round-robin pointer at the end of RESP.
REQ-022 Latency: for a request sampled at edge E0 in IDLE, bram_en SHALL be high during E0..E1 and ack SHALL be high during E2..E3.
REQ-023 SHALL allow the next grant at E3 at the earliest, giving one access per 3 cycles.
REQ-024 SHALL present rdata for writes as well as reads (read-during-write value of the BRAM); the requester ignores it when we≠0.
REQ-025 Address check at grant: if addr > ADDR_HIGH or addr[1:0] ≠ 0, SHALL keep bram_en=0 throughout, still pass through ISSUE, WAIT and RESP, and assert ack together with err for that requester, with rdata=0.
REQ-026 SHALL never issue ack0 and ack1 in the same cycle, and SHALL never issue more than one ack per grant.
REQ-027 SHALL sample a request that stays high through E3 as a new request; the requester drops req during its ack cycle if it wants no further transaction.
REQ-028 SHALL ignore a request that drops before being granted, with no side effects.
REQ-029 SHALL leave a request arriving while busy=1 pending until IDLE.

Reset
REQ-030 On rst_n=0, at any time including mid-transaction, SHALL immediately force: state=IDLE; bram_en, bram_we, bram_addr, bram_wrdata, rdata, ack0/1, err0/1 and busy to 0; round-robin pointer to requester 0.
REQ-031 SHALL complete no in-flight transaction and generate no ack after reset.
REQ-032 After rst_n rises, SHALL accept the first request at the first clk edge.

Verification
REQ-033 Single read: req0=1, addr0=0x10, we0=0, BRAM holds 0xDEADBEEF at 0x10 -> bram_en is high one cycle at addr 0x10, and ack0=1 with rdata=0xDEADBEEF three cycles after sampling.
REQ-034 Write then read: req1 writes 0x12345678 with we1=4'hF to 0xFFC -> ack1 with err1=0; a following read of 0xFFC by req1 returns 0x12345678.
REQ-035 Contention: req0 and req1 both held high for 4 transactions each -> grants alternate 0,1,0,1,..., with acks spaced 3 cycles apart and no dual ack.
REQ-036 Fixed priority: RR_EN=0, both requesters held high -> only ack0 until req0 drops, then ack1.
REQ-037 Error path: addr0=0x1000 or addr0=0x2 -> bram_en stays 0, ack0=1 with err0=1 and rdata=0.
REQ-038 Reset mid-transaction: rst_n pulled low while in WAIT -> all outputs 0 at once; no ack after release; the next request completes normally with requester 0 having priority.
